// File: rtl/amplitude_window_reporter.sv
// amplitude_window_reporter
// Counts valid samples in fixed-length windows. At the end of each window it
// captures the external min/max tracker outputs, derives peak-to-peak and
// peak magnitude, clears the tracker and offers the result over a
// valid/ready handshake. A report that is overwritten before transfer sets
// a sticky overrun flag.
// Optional feature: define AMPLITUDE_CLIP_DETECT_EN to add rpt_clip_count,
// the saturating count of samples in the window whose magnitude reaches
// CLIP_THRESH.
module amplitude_window_reporter #(
  parameter int unsigned        WINDOW_LEN  = 1024,
  parameter logic signed [15:0] CLIP_THRESH = 16'sh7F00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid,
  input  logic signed [15:0] min_in,
  input  logic signed [15:0] max_in,
  output logic               tracker_clr,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic signed [15:0] rpt_min,
  output logic signed [15:0] rpt_max,
  output logic [16:0]        rpt_p2p,
  output logic [15:0]        rpt_peak,
  output logic [7:0]         rpt_seq,
  output logic               overrun
`ifdef AMPLITUDE_CLIP_DETECT_EN
  ,
  output logic [15:0]        rpt_clip_count
`endif
);

  localparam logic [15:0] LAST_IDX = 16'(WINDOW_LEN - 1);

  typedef enum logic [1:0] {S_COUNT, S_CAPTURE, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               tracker_clr_q, tracker_clr_d;
  logic               rpt_valid_q, rpt_valid_d;
  logic               overrun_q, overrun_d;
  logic signed [15:0] rpt_min_q, rpt_max_q;
  logic [16:0]        rpt_p2p_q;
  logic [15:0]        rpt_peak_q;
  logic [7:0]         rpt_seq_q;
  logic               win_done;
  logic               capture_en;
  logic               xfer;

  // Magnitude of a 16-bit signed value; -32768 maps to 16'h8000.
  function automatic logic [15:0] abs_mag(input logic signed [15:0] v);
    logic signed [16:0] w;
    w = {v[15], v};
    if (w < 0) w = -w;
    return w[15:0];
  endfunction

  // Peak-to-peak in 17 bits so the full signed span fits without wrap.
  function automatic logic [16:0] p2p_of(input logic signed [15:0] lo,
                                         input logic signed [15:0] hi);
    return {hi[15], hi} - {lo[15], lo};
  endfunction

  // Larger of the two extremes' magnitudes.
  function automatic logic [15:0] peak_of(input logic signed [15:0] lo,
                                          input logic signed [15:0] hi);
    logic [15:0] a, b;
    a = abs_mag(lo);
    b = abs_mag(hi);
    return (a > b) ? a : b;
  endfunction

  assign win_done   = sample_valid && (cnt_q == LAST_IDX);
  assign capture_en = (state_q == S_CAPTURE);
  assign xfer       = rpt_valid_q && rpt_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_COUNT;
    else     state_q <= state_d;
  end

  // Next-state logic; window completion in HOLD re-captures over the pending report.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_COUNT:   if (win_done) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_HOLD;
      S_HOLD: begin
        if (win_done)  state_d = S_CAPTURE;
        else if (xfer) state_d = S_COUNT;
      end
      default:   state_d = S_COUNT;
    endcase
  end

  // Output/control next values: tracker clear aligned with CAPTURE, valid and overrun updates.
  always_comb begin
    tracker_clr_d = (state_d == S_CAPTURE);
    rpt_valid_d   = rpt_valid_q;
    if (capture_en)  rpt_valid_d = 1'b1;
    else if (xfer)   rpt_valid_d = 1'b0;
    overrun_d     = overrun_q | (capture_en & rpt_valid_q & ~rpt_ready);
    cnt_d         = cnt_q;
    if (sample_valid) cnt_d = win_done ? 16'd0 : cnt_q + 16'd1;
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      tracker_clr_q <= 1'b0;
      rpt_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      tracker_clr_q <= tracker_clr_d;
      rpt_valid_q   <= rpt_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  // Report fields, captured once per window during CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_min_q  <= '0;
      rpt_max_q  <= '0;
      rpt_p2p_q  <= '0;
      rpt_peak_q <= '0;
      rpt_seq_q  <= '0;
    end else if (capture_en) begin
      rpt_min_q  <= min_in;
      rpt_max_q  <= max_in;
      rpt_p2p_q  <= p2p_of(min_in, max_in);
      rpt_peak_q <= peak_of(min_in, max_in);
      rpt_seq_q  <= rpt_seq_q + 8'd1;
    end
  end

  assign tracker_clr = tracker_clr_q;
  assign rpt_valid   = rpt_valid_q;
  assign rpt_min     = rpt_min_q;
  assign rpt_max     = rpt_max_q;
  assign rpt_p2p     = rpt_p2p_q;
  assign rpt_peak    = rpt_peak_q;
  assign rpt_seq     = rpt_seq_q;
  assign overrun     = overrun_q;

`ifdef AMPLITUDE_CLIP_DETECT_EN
  localparam logic signed [16:0] CLIP_P = {CLIP_THRESH[15], CLIP_THRESH};
  localparam logic signed [16:0] CLIP_N = -CLIP_P;

  logic signed [16:0] s_ext;
  logic               clip_hit;
  logic [15:0]        clip_cnt_q, clip_cnt_d;
  logic [15:0]        rpt_clip_q;

  assign s_ext    = {sample_in[15], sample_in};
  assign clip_hit = (s_ext >= CLIP_P) || (s_ext <= CLIP_N);

  // Window clip count: restarts at CAPTURE, saturates at 0xFFFF.
  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (capture_en)
      clip_cnt_d = '0;
    else if (sample_valid && clip_hit && (clip_cnt_q != 16'hFFFF))
      clip_cnt_d = clip_cnt_q + 16'd1;
  end

  // Clip counter and its captured report copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_cnt_q <= '0;
      rpt_clip_q <= '0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
      if (capture_en) rpt_clip_q <= clip_cnt_q;
    end
  end

  assign rpt_clip_count = rpt_clip_q;
`endif

endmodule

// File: tb/tb_amplitude_window_reporter.sv
// Bench for amplitude_window_reporter with WINDOW_LEN=4. A behavioural
// min/max tracker feeds min_in/max_in; expected reports are queued when a
// window is driven and compared when the DUT transfers a report.
module tb_amplitude_window_reporter;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic signed [15:0] min_in, max_in;
  logic               tracker_clr;
  logic               rpt_valid;
  logic               rpt_ready = 1'b0;
  logic signed [15:0] rpt_min, rpt_max;
  logic [16:0]        rpt_p2p;
  logic [15:0]        rpt_peak;
  logic [7:0]         rpt_seq;
  logic               overrun;
`ifdef AMPLITUDE_CLIP_DETECT_EN
  logic [15:0]        rpt_clip_count;
`endif

  amplitude_window_reporter #(.WINDOW_LEN(4), .CLIP_THRESH(16'sh7F00)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .min_in(min_in), .max_in(max_in), .tracker_clr(tracker_clr),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_min(rpt_min),
    .rpt_max(rpt_max), .rpt_p2p(rpt_p2p), .rpt_peak(rpt_peak),
    .rpt_seq(rpt_seq), .overrun(overrun)
`ifdef AMPLITUDE_CLIP_DETECT_EN
    , .rpt_clip_count(rpt_clip_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int mn; int mx; int p2p; int peak; int seq; int clip;
  } rpt_t;

  rpt_t sb[$];
  int   exp_seq = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   clr_pulses = 0;

  // External min/max tracker model, cleared by rst or tracker_clr.
  logic               trk_empty;
  logic signed [15:0] trk_mn, trk_mx;
  always_ff @(posedge clk) begin
    if (rst || tracker_clr) begin
      trk_empty <= 1'b1;
      trk_mn    <= '0;
      trk_mx    <= '0;
    end else if (sample_valid) begin
      if (trk_empty || sample_in < trk_mn) trk_mn <= sample_in;
      if (trk_empty || sample_in > trk_mx) trk_mx <= sample_in;
      trk_empty <= 1'b0;
    end
  end
  assign min_in = trk_mn;
  assign max_in = trk_mx;

  always @(negedge clk) if (tracker_clr) clr_pulses++;

  // Scoreboard: every transfer pops one expected report.
  always @(negedge clk) begin
    if (!rst && rpt_valid && rpt_ready) begin
      rpt_t e;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_report: got seq %0d, required no report", rpt_seq);
      end else begin
        e = sb.pop_front();
        if (rpt_min !== 16'(e.mn)) begin
          n_fail++; $display("FAIL rpt_min: got %0d, required %0d", rpt_min, e.mn);
        end
        n_checks++;
        if (rpt_max !== 16'(e.mx)) begin
          n_fail++; $display("FAIL rpt_max: got %0d, required %0d", rpt_max, e.mx);
        end
        n_checks++;
        if (rpt_p2p !== 17'(e.p2p)) begin
          n_fail++; $display("FAIL rpt_p2p: got %h, required %h", rpt_p2p, 17'(e.p2p));
        end
        n_checks++;
        if (rpt_peak !== 16'(e.peak)) begin
          n_fail++; $display("FAIL rpt_peak: got %h, required %h", rpt_peak, 16'(e.peak));
        end
        n_checks++;
        if (rpt_seq !== 8'(e.seq)) begin
          n_fail++; $display("FAIL rpt_seq: got %0d, required %0d", rpt_seq, e.seq);
        end
`ifdef AMPLITUDE_CLIP_DETECT_EN
        n_checks++;
        if (rpt_clip_count !== 16'(e.clip)) begin
          n_fail++; $display("FAIL rpt_clip_count: got %0d, required %0d", rpt_clip_count, e.clip);
        end
`endif
      end
    end
  end

  task automatic push_exp(input int a, input int b, input int c, input int d);
    int s[4];
    rpt_t e;
    int am;
    s = '{a, b, c, d};
    e.mn = s[0]; e.mx = s[0]; e.clip = 0;
    foreach (s[i]) begin
      if (s[i] < e.mn) e.mn = s[i];
      if (s[i] > e.mx) e.mx = s[i];
      if (s[i] >= 32512 || s[i] <= -32512) e.clip++;
    end
    e.p2p  = e.mx - e.mn;
    e.peak = (e.mn < 0) ? -e.mn : e.mn;
    am     = (e.mx < 0) ? -e.mx : e.mx;
    if (am > e.peak) e.peak = am;
    exp_seq = (exp_seq + 1) % 256;
    e.seq   = exp_seq;
    sb.push_back(e);
  endtask

  task automatic drive_sample(input int v);
    @(posedge clk); #1;
    sample_in = 16'(v);
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic send_window(input int a, input int b, input int c, input int d);
    push_exp(a, b, c, d);
    drive_sample(a);
    drive_sample(b);
    drive_sample(c);
    drive_sample(d);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d reports pending, required 0", sb.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_seq = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rpt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", rpt_valid); end
    n_checks++; if (tracker_clr !== 1'b0) begin n_fail++; $display("FAIL rst_clr: got %b, required 0", tracker_clr); end
    n_checks++; if (rpt_min !== 16'sd0) begin n_fail++; $display("FAIL rst_min: got %0d, required 0", rpt_min); end
    n_checks++; if (rpt_max !== 16'sd0) begin n_fail++; $display("FAIL rst_max: got %0d, required 0", rpt_max); end
    n_checks++; if (rpt_p2p !== 17'd0) begin n_fail++; $display("FAIL rst_p2p: got %0d, required 0", rpt_p2p); end
    n_checks++; if (rpt_peak !== 16'd0) begin n_fail++; $display("FAIL rst_peak: got %0d, required 0", rpt_peak); end
    n_checks++; if (rpt_seq !== 8'd0) begin n_fail++; $display("FAIL rst_seq: got %0d, required 0", rpt_seq); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b, required 0", overrun); end
`ifdef AMPLITUDE_CLIP_DETECT_EN
    n_checks++; if (rpt_clip_count !== 16'd0) begin n_fail++; $display("FAIL rst_clip: got %0d, required 0", rpt_clip_count); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    rpt_ready = 1'b1;
    clr_pulses = 0;
    push_exp(100, -50, 300, 7);
    drive_sample(100);
    drive_sample(-50);
    drive_sample(300);
    @(posedge clk); #1;
    sample_in = 16'sd7;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tracker_clr !== 1'b1 || rpt_valid !== 1'b0) begin
      n_fail++; $display("FAIL capture_cycle: clr=%b valid=%b, required clr=1 valid=0", tracker_clr, rpt_valid);
    end
    @(negedge clk);
    n_checks++;
    if (rpt_valid !== 1'b1 || tracker_clr !== 1'b0) begin
      n_fail++; $display("FAIL valid_rise: valid=%b clr=%b, required valid=1 clr=0", rpt_valid, tracker_clr);
    end
    wait_drain(20);
    repeat (2) @(negedge clk);
    n_checks++;
    if (rpt_valid !== 1'b0) begin n_fail++; $display("FAIL valid_drop: got %b, required 0", rpt_valid); end
    n_checks++;
    if (clr_pulses != 1) begin n_fail++; $display("FAIL clr_pulses: got %0d, required 1", clr_pulses); end
  endtask

  task automatic test_extremes();
    rpt_ready = 1'b1;
    send_window(32767, -32768, 0, 1);
    wait_drain(20);
  endtask

  task automatic test_overrun();
    do_reset();
    rpt_ready = 1'b0;
    send_window(10, 20, 30, 40);
    send_window(-5, 1000, 3, -2000);
    @(negedge clk);
    n_checks++;
    if (rpt_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b, required 1", rpt_valid); end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b, required 1", overrun); end
    n_checks++;
    if (rpt_seq !== 8'd2) begin n_fail++; $display("FAIL ovr_seq: got %0d, required 2", rpt_seq); end
    void'(sb.pop_front());
    rpt_ready = 1'b1;
    wait_drain(20);
    repeat (2) @(negedge clk);
    n_checks++;
    if (rpt_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_single_xfer: valid=%b, required 0", rpt_valid); end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b, required 1", overrun); end
  endtask

  task automatic test_reset_hold();
    rpt_ready = 1'b0;
    send_window(1, 2, 3, 4);
    @(negedge clk);
    n_checks++;
    if (rpt_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b, required 1", rpt_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (rpt_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b, required 0", rpt_valid); end
    n_checks++;
    if (rpt_seq !== 8'd0) begin n_fail++; $display("FAIL async_seq: got %0d, required 0", rpt_seq); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL async_overrun: got %b, required 0", overrun); end
    sb.delete();
    exp_seq = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Partial window followed by reset must leave no trace.
    drive_sample(500);
    drive_sample(-500);
    do_reset();
    rpt_ready = 1'b1;
    send_window(-7, -3, -9, -1);
    wait_drain(20);
    repeat (30) @(negedge clk);
  endtask

  task automatic test_idle();
    int seen = 0;
    do_reset();
    rpt_ready = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (rpt_valid || tracker_clr) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL idle_report: got %0d active cycles, required 0", seen); end
  endtask

  task automatic test_wrap();
    logic signed [15:0] r[4];
    do_reset();
    rpt_ready = 1'b1;
    for (int w = 0; w < 300; w++) begin
      foreach (r[i]) r[i] = 16'($urandom);
      send_window(int'(r[0]), int'(r[1]), int'(r[2]), int'(r[3]));
    end
    wait_drain(40);
    @(negedge clk);
    n_checks++;
    if (rpt_seq !== 8'd44) begin n_fail++; $display("FAIL wrap_seq: got %0d, required 44", rpt_seq); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL wrap_overrun: got %b, required 0", overrun); end
  endtask

`ifdef AMPLITUDE_CLIP_DETECT_EN
  task automatic test_clip();
    do_reset();
    rpt_ready = 1'b1;
    send_window(32512, -32512, 32511, 0);
    wait_drain(20);
    n_checks++;
    if (rpt_clip_count !== 16'd2) begin n_fail++; $display("FAIL clip_count: got %0d, required 2", rpt_clip_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_overrun();
    test_reset_hold();
    test_idle();
    test_wrap();
`ifdef AMPLITUDE_CLIP_DETECT_EN
    test_clip();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/amplitude_window_reporter.md
AMPLITUDE_WINDOW_REPORTER -- requirements
Module: amplitude_window_reporter

Interface
REQ-001 SHALL have parameter WINDOW_LEN, default 1024, number of valid samples per report window (2..65535).
REQ-002 SHALL have parameter CLIP_THRESH, default 16'sh7F00, signed magnitude at or above which a sample counts as clipped.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sample_in, input, 16, signed sample, the same value fed to the min/max tracker.
REQ-006 SHALL have port sample_valid, input, 1, the same strobe fed to the tracker.
REQ-007 SHALL have ports min_in and max_in, input, 16 each, signed, driven from tracker min_out/max_out.
REQ-008 SHALL have port tracker_clr, output, 1, registered one-cycle pulse OR-ed into the tracker's rst.
REQ-009 SHALL have ports rpt_valid (output, 1) and rpt_ready (input, 1), report handshake.
REQ-010 SHALL have ports rpt_min and rpt_max, output, 16 each, signed captured extremes.
REQ-011 SHALL have port rpt_p2p, output, 17, unsigned max-min.
REQ-012 SHALL have port rpt_peak, output, 16, unsigned max(|min|,|max|).
REQ-013 SHALL have port rpt_seq, output, 8, window sequence number.
REQ-014 SHALL have port overrun, output, 1, sticky lost-report flag.

Function
REQ-015 SHALL count sample_valid pulses in a 16-bit window counter; upstream guarantees at least 2 clk between pulses.
REQ-016 SHALL run FSM states COUNT, CAPTURE, HOLD; reset state COUNT.
REQ-017 COUNT: on sample_valid with counter==WINDOW_LEN-1, SHALL zero the counter and go to CAPTURE next cycle.
REQ-018 CAPTURE (exactly one cycle): SHALL latch min_in/max_in into rpt_min/rpt_max, compute p2p/peak, increment rpt_seq (8-bit wrap 255->0), pulse tracker_clr for this cycle only, then go to HOLD.
REQ-019 rpt_valid SHALL rise on the cycle after CAPTURE; report fields SHALL be stable while rpt_valid is high.
REQ-020 HOLD: transfer occurs on rpt_valid && rpt_ready; rpt_valid SHALL drop the next cycle; FSM returns to COUNT.
REQ-021 Sample counting SHALL continue in HOLD; if another window completes while rpt_valid is still high, the new capture SHALL overwrite the fields, rpt_valid SHALL stay high, and overrun SHALL set.
REQ-022 rpt_p2p SHALL be computed in 17 bits: 0x7FFF minus -0x8000 = 0x0FFFF, with no wrap.
REQ-023 rpt_peak SHALL map |-32768| to 16'h8000 (unsigned, no saturation).
REQ-024 With sample_valid never asserted, no report SHALL ever be produced.

Reset
REQ-025 On rst: FSM=COUNT, counter=0, rpt_valid=0, tracker_clr=0, rpt_min=0, rpt_max=0, rpt_p2p=0, rpt_peak=0, rpt_seq=0, overrun=0, clip_count=0.
REQ-026 Reset mid-window or mid-HOLD SHALL discard the pending report immediately; no partial report SHALL follow.
REQ-027 overrun SHALL clear only on rst.

Configuration
REQ-028 Macro AMPLITUDE_CLIP_DETECT_EN: when defined, SHALL add output rpt_clip_count (16 bits, saturating at 0xFFFF) holding the count of samples in the window with sample_in >= CLIP_THRESH or sample_in <= -CLIP_THRESH, latched in CAPTURE, with the internal counter reset to 0 at window start.
REQ-029 Without AMPLITUDE_CLIP_DETECT_EN, the port and logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 WINDOW_LEN=4, samples 100,-50,300,7, rpt_ready=1 -> one report with min=-50, max=300, p2p=350, peak=300, seq=1, a single tracker_clr pulse.
REQ-031 Samples 0x7FFF and 0x8000 in one window -> p2p=0x0FFFF, peak=0x8000.
REQ-032 rpt_ready=0 for two full windows -> overrun=1, fields from window 2, seq=2; rpt_ready=1 -> one transfer.
REQ-033 rst asserted in HOLD with rpt_valid=1 -> rpt_valid=0 asynchronously, seq=0; next report seq=1.
REQ-034 300 windows with rpt_ready=1 -> seq wraps 255->0->44, with no overrun.
REQ-035 AMPLITUDE_CLIP_DETECT_EN, CLIP_THRESH=0x7F00, window 0x7F00,-0x7F00,0x7EFF,0 -> rpt_clip_count=2.
